// File: rtl/axi_ram_pkg.sv
// Shared types and constants for the single-beat AXI RAM slave.
package axi_ram_pkg;

  localparam int ID_W   = 4;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_GOT_AW,
    W_GOT_W,
    W_RESP
  } w_state_t;

  // Overlay the strobed byte lanes of new_word onto old_word.
  function automatic logic [DATA_W-1:0] strb_merge(input logic [DATA_W-1:0] old_word,
                                                   input logic [DATA_W-1:0] new_word,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi_ram_array.sv
// Synchronous word RAM with per-byte write enables and a registered read port.
// A read and write to the same word on the same edge returns the new bytes.
module axi_ram_array
  import axi_ram_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Byte-lane writes; the storage itself is never cleared, and reset blocks any commit.
  always_ff @(posedge clk) begin
    if (resetn && we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Registered read with write-first forwarding on an address collision.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if (we && (wr_addr == rd_addr)) rd_data <= strb_merge(mem[rd_addr], wr_data, wr_strb);
      else                            rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/axi_ram_slave.sv
// Single-beat AXI4 RAM slave with independent read and write channels.
// One read and one write may be outstanding at the same time.
module axi_ram_slave
  import axi_ram_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ID_W-1:0]   arid,
  input  logic [31:0]       araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ID_W-1:0]   awid,
  input  logic [31:0]       awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  // Cycles spent in R_WAIT before the capture edge; RD_LAT=1 captures on the AR edge itself.
  localparam logic [3:0] WAIT_LOAD = (RD_LAT >= 2) ? 4'(RD_LAT - 2) : 4'd0;

  logic [ADDR_W-1:0] ar_idx;
  logic [ADDR_W-1:0] aw_idx;
  logic              unused_addr_bits;

  assign ar_idx = araddr[ADDR_W+1:2];
  assign aw_idx = awaddr[ADDR_W+1:2];
  assign unused_addr_bits = &{1'b0, araddr[31:ADDR_W+2], araddr[1:0],
                              awaddr[31:ADDR_W+2], awaddr[1:0]};

  // ---------------- read channel ----------------
  r_state_t          r_state, r_state_nxt;
  logic [3:0]        r_cnt, r_cnt_nxt;
  logic [ID_W-1:0]   rid_q;
  logic [ADDR_W-1:0] r_idx_q;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_idx;

  // Read next-state, countdown and RAM read-port control.
  always_comb begin
    r_state_nxt = r_state;
    r_cnt_nxt   = r_cnt;
    arready     = 1'b0;
    rvalid      = 1'b0;
    rd_en       = 1'b0;
    rd_idx      = r_idx_q;
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          if (RD_LAT == 1) begin
            rd_en       = 1'b1;
            rd_idx      = ar_idx;
            r_state_nxt = R_RESP;
          end else begin
            r_cnt_nxt   = WAIT_LOAD;
            r_state_nxt = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_cnt == 4'd0) begin
          rd_en       = 1'b1;
          r_state_nxt = R_RESP;
        end else begin
          r_cnt_nxt = r_cnt - 4'd1;
        end
      end
      R_RESP: begin
        rvalid = 1'b1;
        if (rready) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Read state register and AR capture.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= R_IDLE;
      r_cnt   <= 4'd0;
      rid_q   <= '0;
      r_idx_q <= '0;
    end else begin
      r_state <= r_state_nxt;
      r_cnt   <= r_cnt_nxt;
      if (arready && arvalid) begin
        rid_q   <= arid;
        r_idx_q <= ar_idx;
      end
    end
  end

  assign rid   = rid_q;
  assign rresp = RESP_OKAY;
  assign rlast = rvalid;

  // ---------------- write channel ----------------
  w_state_t          w_state, w_state_nxt;
  logic [ID_W-1:0]   aw_id_q;
  logic [ADDR_W-1:0] aw_idx_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic [ID_W-1:0]   bid_q;
  logic              we;
  logic [ADDR_W-1:0] wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic [ID_W-1:0]   commit_id;

  // Write next-state; the commit takes whichever half arrives last straight from the bus.
  always_comb begin
    w_state_nxt = w_state;
    awready     = 1'b0;
    wready      = 1'b0;
    bvalid      = 1'b0;
    we          = 1'b0;
    wr_idx      = aw_idx_q;
    wr_data     = w_data_q;
    wr_strb     = w_strb_q;
    commit_id   = aw_id_q;
    case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        wready  = 1'b1;
        if (awvalid && wvalid) begin
          we          = 1'b1;
          wr_idx      = aw_idx;
          wr_data     = wdata;
          wr_strb     = wstrb;
          commit_id   = awid;
          w_state_nxt = W_RESP;
        end else if (awvalid) begin
          w_state_nxt = W_GOT_AW;
        end else if (wvalid) begin
          w_state_nxt = W_GOT_W;
        end
      end
      W_GOT_AW: begin
        wready = 1'b1;
        if (wvalid) begin
          we          = 1'b1;
          wr_data     = wdata;
          wr_strb     = wstrb;
          w_state_nxt = W_RESP;
        end
      end
      W_GOT_W: begin
        awready = 1'b1;
        if (awvalid) begin
          we          = 1'b1;
          wr_idx      = aw_idx;
          commit_id   = awid;
          w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Write state register, AW/W holding registers and response ID.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_state  <= W_IDLE;
      aw_id_q  <= '0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bid_q    <= '0;
    end else begin
      w_state <= w_state_nxt;
      if (awready && awvalid) begin
        aw_id_q  <= awid;
        aw_idx_q <= aw_idx;
      end
      if (wready && wvalid) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (we) bid_q <= commit_id;
    end
  end

  assign bid   = bid_q;
  assign bresp = RESP_OKAY;

  axi_ram_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk    (clk),
    .resetn (resetn),
    .we     (we),
    .wr_addr(wr_idx),
    .wr_data(wr_data),
    .wr_strb(wr_strb),
    .rd_en  (rd_en),
    .rd_addr(rd_idx),
    .rd_data(rdata)
  );

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: one instance with RD_LAT=2, one with RD_LAT=1.
// Both share the input bus; 'sel' chooses which instance the checks observe.
module tb_axi_ram_slave;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr, wdata;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic [3:0]  wstrb;

  logic [1:0]  arready_v, rlast_v, rvalid_v, awready_v, wready_v, bvalid_v;
  logic [3:0]  rid_v [2];
  logic [3:0]  bid_v [2];
  logic [31:0] rdata_v [2];
  logic [1:0]  rresp_v [2];
  logic [1:0]  bresp_v [2];

  int sel = 0;
  int errors = 0;
  int checks = 0;

  logic        arready, rlast, rvalid, awready, wready, bvalid;
  logic [3:0]  rid, bid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  assign arready = arready_v[sel];
  assign rlast   = rlast_v[sel];
  assign rvalid  = rvalid_v[sel];
  assign awready = awready_v[sel];
  assign wready  = wready_v[sel];
  assign bvalid  = bvalid_v[sel];
  assign rid     = rid_v[sel];
  assign bid     = bid_v[sel];
  assign rdata   = rdata_v[sel];
  assign rresp   = rresp_v[sel];
  assign bresp   = bresp_v[sel];

  always #5 clk = ~clk;

  axi_ram_slave #(.ADDR_W(10), .RD_LAT(2)) dut_lat2 (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready_v[0]),
    .rid(rid_v[0]), .rdata(rdata_v[0]), .rresp(rresp_v[0]), .rlast(rlast_v[0]),
    .rvalid(rvalid_v[0]), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready_v[0]),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready_v[0]),
    .bid(bid_v[0]), .bresp(bresp_v[0]), .bvalid(bvalid_v[0]), .bready(bready)
  );

  axi_ram_slave #(.ADDR_W(10), .RD_LAT(1)) dut_lat1 (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready_v[1]),
    .rid(rid_v[1]), .rdata(rdata_v[1]), .rresp(rresp_v[1]), .rlast(rlast_v[1]),
    .rvalid(rvalid_v[1]), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready_v[1]),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready_v[1]),
    .bid(bid_v[1]), .bresp(bresp_v[1]), .bvalid(bvalid_v[1]), .bready(bready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", tag, actual, expected);
    end
  endtask

  task automatic doReset();
    resetn  = 1'b0;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    rready  = 1'b0; bready  = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  // Write with AW and W presented together, then hold bready low for 'hold' cycles.
  task automatic applyStimulus(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int hold, input string tag);
    int n;
    awid = id; awaddr = addr; awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    bready = 1'b0;
    n = 0;
    while (!(awready && wready) && n < 20) begin tick(); n++; end
    checkOutput({tag, " aw_w_ready"}, {awready, wready}, 2'b11);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    checkOutput({tag, " bresp"}, {bvalid, bid, bresp}, {1'b1, id, 2'b00});
    for (int i = 0; i < hold; i++) begin
      tick();
      checkOutput({tag, " b_hold"}, {bvalid, bid, awready, wready}, {1'b1, id, 1'b0, 1'b0});
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checkOutput({tag, " b_done"}, {bvalid, awready, wready}, 3'b011);
  endtask

  // Read, checking latency from the AR handshake edge, then stall rready for 'hold' cycles.
  task automatic doRead(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] exp_data,
                        input int exp_lat, input int hold, input string tag);
    int n;
    arid = id; araddr = addr; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    checkOutput({tag, " ar_ready"}, arready, 1);
    tick();
    arvalid = 1'b0;
    n = 1;
    while (!rvalid && n < 20) begin tick(); n++; end
    checkOutput({tag, " latency"}, 64'(n), 64'(exp_lat));
    checkOutput({tag, " rdata"}, rdata, exp_data);
    checkOutput({tag, " rid_rlast_rresp"}, {rid, rlast, rresp}, {id, 1'b1, 2'b00});
    for (int i = 0; i < hold; i++) begin
      tick();
      checkOutput({tag, " r_hold"}, {rvalid, arready, rid, rdata}, {1'b1, 1'b0, id, exp_data});
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    checkOutput({tag, " r_done"}, {rvalid, arready}, 2'b01);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;
    resetn = 1'b0;
    arid = '0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;

    // ---------- RD_LAT = 2 instance ----------
    sel = 0;
    doReset();
    checkOutput("rst ready", {arready, awready, wready}, 3'b111);
    checkOutput("rst valids", {rvalid, bvalid}, 2'b00);
    checkOutput("rst ids", {rid, bid}, 8'h00);
    checkOutput("rst rdata", rdata, 32'h0);

    applyStimulus(4'd1, 32'h40, 32'h12345678, 4'b1111, 0, "wr_full");
    doRead(4'd0, 32'h40, 32'h12345678, 2, 0, "rd_full");

    applyStimulus(4'd2, 32'h40, 32'hAABBCCDD, 4'b0010, 0, "wr_lane1");
    doRead(4'd3, 32'h40, 32'h1234CC78, 2, 0, "rd_lane1");

    applyStimulus(4'd4, 32'h40, 32'hFFFFFFFF, 4'b0000, 0, "wr_nostrb");
    doRead(4'd3, 32'h40, 32'h1234CC78, 2, 0, "rd_nostrb");

    // W presented three cycles ahead of AW.
    awid = 4'd5; awaddr = 32'h44; awvalid = 1'b0;
    wdata = 32'h0BADBEEF; wstrb = 4'b1111; wvalid = 1'b1; bready = 1'b0;
    checkOutput("w_first ready", {awready, wready}, 2'b11);
    tick();
    wvalid = 1'b0;
    checkOutput("w_first got_w", {awready, wready}, 2'b10);
    tick();
    tick();
    awvalid = 1'b1;
    checkOutput("w_first aw_ready", {awready, wready}, 2'b10);
    tick();
    awvalid = 1'b0;
    checkOutput("w_first bresp", {bvalid, bid, bresp, awready, wready}, {1'b1, 4'd5, 2'b00, 1'b0, 1'b0});
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("w_first b_hold", {bvalid, bid, awready, wready}, {1'b1, 4'd5, 1'b0, 1'b0});
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checkOutput("w_first b_done", {bvalid, awready, wready}, 3'b011);

    doRead(4'd7, 32'h44, 32'h0BADBEEF, 2, 5, "rd_stall");
    applyStimulus(4'd8, 32'h48, 32'h55AA55AA, 4'b1111, 5, "wr_stall");

    // Reset while the read waits and the write holds only its address.
    arid = 4'd9; araddr = 32'h48; arvalid = 1'b1;
    awid = 4'd10; awaddr = 32'h48; awvalid = 1'b1; wvalid = 1'b0;
    tick();
    arvalid = 1'b0; awvalid = 1'b0;
    checkOutput("mid busy", {arready, awready, wready}, 3'b001);
    resetn = 1'b0;
    wdata = 32'hDEADDEAD; wstrb = 4'b1111; wvalid = 1'b1;
    tick();
    resetn = 1'b1;
    wvalid = 1'b0;
    checkOutput("mid rst ready", {arready, awready, wready, rvalid, bvalid}, 5'b11100);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rvalid || bvalid) seen++;
    end
    checkOutput("mid no_resp", 64'(seen), 64'd0);
    doRead(4'd11, 32'h48, 32'h55AA55AA, 2, 0, "mid rd_intact");

    // ---------- RD_LAT = 1 instance ----------
    sel = 1;
    doReset();
    checkOutput("lat1 rst ready", {arready, awready, wready, rvalid, bvalid}, 5'b11100);
    applyStimulus(4'd3, 32'h80, 32'h11111111, 4'b1111, 0, "lat1 wr_old");

    // Read capture and write commit to word 0x80 on the same edge.
    arid = 4'd4; araddr = 32'h80; arvalid = 1'b1;
    awid = 4'd6; awaddr = 32'h80; awvalid = 1'b1;
    wdata = 32'hCAFEF00D; wstrb = 4'b1111; wvalid = 1'b1;
    rready = 1'b0; bready = 1'b0;
    checkOutput("bypass ready", {arready, awready, wready}, 3'b111);
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    checkOutput("bypass valids", {rvalid, bvalid}, 2'b11);
    checkOutput("bypass rdata", rdata, 32'hCAFEF00D);
    checkOutput("bypass ids", {rid, bid}, {4'd4, 4'd6});
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    checkOutput("bypass done", {rvalid, bvalid, arready, awready}, 4'b0011);

    doRead(4'd9, 32'h1080, 32'hCAFEF00D, 1, 0, "lat1 rd_alias");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_ram_slave.md
AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning the log2 of the word depth (1024 x 32-bit words).
REQ-002 The block SHALL have parameter RD_LAT, default 2, meaning the number of cycles from AR handshake to first rvalid (legal range 1..15).
REQ-003 The block SHALL have port clk  in  1  clock; all logic on its rising edge.
REQ-004 The block SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port arid  in  4  read ID.
REQ-006 The block SHALL have port araddr  in  32  read byte address.
REQ-007 The block SHALL have port arvalid  in  1  read address valid.
REQ-008 The block SHALL have port arready  out  1  read address accepted.
REQ-009 The block SHALL have port rid  out  4  echoed read ID.
REQ-010 The block SHALL have port rdata  out  32  read data.
REQ-011 The block SHALL have port rresp  out  2  read response, always 2'b00.
REQ-012 The block SHALL have port rlast  out  1  always equal to rvalid.
REQ-013 The block SHALL have port rvalid  out  1  read data valid.
REQ-014 The block SHALL have port rready  in  1  master accepts read data.
REQ-015 The block SHALL have port awid  in  4  write ID.
REQ-016 The block SHALL have port awaddr  in  32  write byte address.
REQ-017 The block SHALL have port awvalid  in  1  write address valid.
REQ-018 The block SHALL have port awready  out  1  write address accepted.
REQ-019 The block SHALL have port wdata  in  32  write data.
REQ-020 The block SHALL have port wstrb  in  4  byte-lane enables.
REQ-021 The block SHALL have port wvalid  in  1  write data valid.
REQ-022 The block SHALL have port wready  out  1  write data accepted.
REQ-023 The block SHALL have port bid  out  4  echoed write ID.
REQ-024 The block SHALL have port bresp  out  2  write response, always 2'b00.
REQ-025 The block SHALL have port bvalid  out  1  write response valid.
REQ-026 The block SHALL have port bready  in  1  master accepts write response.

Function
REQ-027 The block SHALL support single-beat transfers only, with len, size, burst, lock, cache and prot not connected; the word index is addr[ADDR_W+1:2], with addr[1:0] and upper bits ignored (addresses wrap modulo depth).
REQ-028 The read FSM SHALL have states R_IDLE, R_WAIT and R_RESP, with arready=1 only in R_IDLE, giving one outstanding read.
REQ-029 An AR handshake SHALL latch arid and the word index, load a counter, and enter R_WAIT.
REQ-030 rvalid SHALL rise exactly RD_LAT cycles after the AR handshake cycle (RD_LAT=1 means the next cycle).
REQ-031 rdata SHALL be captured from the array on the edge entering R_RESP, and rid/rdata SHALL be held stable while rvalid=1 and rready=0.
REQ-032 An R handshake SHALL return the FSM to R_IDLE, with arready high the following cycle (no same-cycle re-accept).
REQ-033 The write FSM SHALL have states W_IDLE, W_GOT_AW, W_GOT_W and W_RESP, with awready=1 in W_IDLE/W_GOT_W and wready=1 in W_IDLE/W_GOT_AW.
REQ-034 AW and W SHALL be accepted in either order or in the same cycle, with the latched id/index/data/strb committed on the edge that completes the second handshake, entering W_RESP.
REQ-035 The write commit SHALL update only byte lanes whose wstrb bit is 1, and wstrb=4'b0000 SHALL leave the array unchanged but still produce a response.
REQ-036 bvalid SHALL be 1 throughout W_RESP and the cycle after the commit edge, with bid equal to the latched awid, and a B handshake SHALL return the FSM to W_IDLE.
REQ-037 The read and write FSMs SHALL be fully independent, so that one read and one write may be in flight at the same time.
REQ-038 If a read capture and a write commit to the same word occur on the same edge, the block SHALL return the newly written bytes (write-first bypass).

Reset
REQ-039 While resetn=0, both FSMs SHALL go idle, arready, awready and wready SHALL be 1 on the first cycle after release, and rvalid, bvalid, rid, bid and rdata SHALL be 0.
REQ-040 A reset mid-transaction SHALL abandon the transaction with no response and no partial write, and the array contents SHALL NOT be reset.

Structure
REQ-041 Package axi_ram_pkg SHALL hold the read/write state encodings, RESP_OKAY=2'b00 and the ID width constant.
REQ-042 The block SHALL instantiate one sub-module, axi_ram_array, a synchronous 32-bit RAM with 4 byte-write enables and the write-first bypass.

Verification
REQ-043 A bench SHALL write 0x12345678 to 0x40 with strb 4'b1111 and awid=1, then read 0x40 with arid=0 and RD_LAT=2 -> bid=1, bresp=0; rvalid exactly 2 cycles after AR handshake, rdata=0x12345678, rid=0, rlast=1.
REQ-044 A bench SHALL write 0xAABBCCDD to 0x40 with strb 4'b0010, then read -> 0x1234CC78.
REQ-045 A bench SHALL present W 3 cycles before AW -> wready handshake first, awready then accepts AW, bvalid in the next cycle, awready=0 and wready=0 until the B handshake.
REQ-046 A bench SHALL hold rready=0 for 5 cycles, and likewise bready=0 for 5 cycles -> rvalid/rdata and bvalid/bid stay stable, arready/awready stay 0, and the next read/write is accepted 1 cycle after the handshake.
REQ-047 A bench SHALL, with RD_LAT=1, time the read capture of word 0x80 on the same edge as a write commit of 0xCAFEF00D to 0x80 -> rdata=0xCAFEF00D, and a read of 0x1080 with ADDR_W=10 SHALL alias to 0x80.
REQ-048 A bench SHALL drive resetn=0 for 1 cycle during R_WAIT and during W_GOT_AW -> no rvalid/bvalid ever asserted, the array is unchanged, and arready, awready and wready are 1 after release.
